// File: rtl/rx_link_pkg.sv
// Shared types and helpers for the RX lane alignment controller.
package rx_link_pkg;

  // Encodings are visible on link_state, so keep them fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAlign   = 3'd1,
    StByteord = 3'd2,
    StLinked  = 3'd3,
    StResync  = 3'd4,
    StPhyrst  = 3'd5
  } link_state_e;

  // Comma character the word aligner locks onto.
  localparam logic [7:0] K28_5 = 8'hBC;

  // Both byte lanes in sync.
  localparam logic [1:0] SYNC_ALL = 2'b11;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rx_link_align_ctrl_err_window.sv
// Error-rate supervision while linked: free-running window, per-window error
// count with threshold detect, and a saturating lifetime error total.
module rx_err_window
  import rx_link_pkg::*;
#(
  parameter int unsigned ERR_WINDOW = 4096,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        active_i,
  input  logic        err_i,
  output logic        thresh_hit_o,
  output logic [15:0] err_total_o
);

  // ERR_WINDOW is a power of two, so the window counter wraps on its own.
  localparam int unsigned WinW = $clog2(ERR_WINDOW);
  localparam int unsigned CntW = cnt_width(ERR_THRESH);

  logic [WinW-1:0] win_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     err_total_q;
  logic            wrap;

  assign wrap = (win_q == WinW'(ERR_WINDOW - 1));

  // An error in the last cycle of a window still belongs to that window.
  assign thresh_hit_o = active_i & err_i & (cnt_q == CntW'(ERR_THRESH - 1));
  assign err_total_o  = err_total_q;

  // Window state is held at zero outside LINKED so every LINKED entry starts fresh.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q       <= '0;
      cnt_q       <= '0;
      err_total_q <= '0;
    end else if (!active_i) begin
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      win_q <= win_q + 1'b1;
      if (wrap) begin
        cnt_q <= '0;
      end else if (err_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (err_i && (err_total_q != 16'hFFFF)) begin
        err_total_q <= err_total_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_link_align_ctrl.sv
// Bring-up and supervision sequencer for an 8b/10b receive lane: waits for
// lock, drives word alignment and byte ordering, then watches link health.
module rx_link_align_ctrl
  import rx_link_pkg::*;
#(
  parameter int unsigned ALIGN_TIMEOUT = 1024,
  parameter int unsigned SYNC_STABLE   = 16,
  parameter int unsigned LOSS_CYCLES   = 4,
  parameter int unsigned ERR_WINDOW    = 4096,
  parameter int unsigned ERR_THRESH    = 8,
  parameter int unsigned RESYNC_HOLD   = 32
) (
  input  logic        rx_std_clkout,
  input  logic        rst_n,
  input  logic        rx_ready,
  input  logic        rx_is_lockedtodata,
  input  logic [1:0]  rx_syncstatus,
  input  logic [1:0]  rx_errdetect,
  input  logic [1:0]  rx_disperr,
  input  logic        rx_std_byteorder_flag,
  output logic        rx_std_wa_patternalign,
  output logic        rx_std_byteorder_ena,
  output logic        phy_reset_req,
  output logic        link_up,
  output logic [2:0]  link_state,
  output logic [15:0] err_total,
  output logic [7:0]  relink_cnt
);

  localparam int unsigned TmoW  = cnt_width(ALIGN_TIMEOUT);
  localparam int unsigned StbW  = cnt_width(SYNC_STABLE);
  localparam int unsigned LossW = cnt_width(LOSS_CYCLES);
  localparam int unsigned HoldW = cnt_width(RESYNC_HOLD);

  link_state_e      state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [StbW-1:0]  stable_q, stable_d;
  logic [LossW-1:0] loss_q, loss_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             wa_q, ena_q, req_q, link_up_q;
  logic [7:0]       relink_q;

  logic lock, sync_ok, err_cycle, thresh_hit;
  logic tmo_hit, stable_hit, loss_hit, hold_done;

  assign lock      = rx_ready & rx_is_lockedtodata;
  assign sync_ok   = (rx_syncstatus == SYNC_ALL);
  assign err_cycle = (|rx_errdetect) | (|rx_disperr);

  // Timeout counter saturates so a late ALIGN exit cannot wrap it in BYTEORD.
  assign tmo_inc    = (tmo_q == TmoW'(ALIGN_TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
  assign tmo_hit    = (tmo_q >= TmoW'(ALIGN_TIMEOUT - 1));
  assign stable_hit = sync_ok & (stable_q == StbW'(SYNC_STABLE - 1));
  assign loss_hit   = ~sync_ok & (loss_q == LossW'(LOSS_CYCLES - 1));
  assign hold_done  = (hold_q == HoldW'(RESYNC_HOLD - 1));

  rx_err_window #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_window (
    .clk_i        (rx_std_clkout),
    .rst_ni       (rst_n),
    .active_i     (state_q == StLinked),
    .err_i        (err_cycle),
    .thresh_hit_o (thresh_hit),
    .err_total_o  (err_total)
  );

  // Next state: loss of lock beats everything; exit conditions beat timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (lock) state_d = StAlign;
      StAlign: begin
        if (!lock)           state_d = StIdle;
        else if (stable_hit) state_d = StByteord;
        else if (tmo_hit)    state_d = StPhyrst;
      end
      StByteord: begin
        if (!lock)                      state_d = StIdle;
        else if (rx_std_byteorder_flag) state_d = StLinked;
        else if (tmo_hit)               state_d = StPhyrst;
      end
      StLinked: begin
        if (!lock)                      state_d = StIdle;
        else if (loss_hit || thresh_hit) state_d = StResync;
      end
      StResync: begin
        if (!lock)          state_d = StIdle;
        else if (hold_done) state_d = StAlign;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Per-state counters restart on entry; the timeout carries across ALIGN->BYTEORD.
  always_comb begin
    tmo_d    = '0;
    stable_d = '0;
    loss_d   = '0;
    hold_d   = '0;
    if ((state_q == StAlign) && (state_d == StByteord)) begin
      tmo_d = tmo_inc;
    end else if (state_d == state_q) begin
      case (state_q)
        StAlign: begin
          tmo_d    = tmo_inc;
          stable_d = sync_ok ? stable_q + 1'b1 : '0;
        end
        StByteord: tmo_d  = tmo_inc;
        StLinked:  loss_d = sync_ok ? '0 : loss_q + 1'b1;
        StResync:  hold_d = hold_q + 1'b1;
        default:   ;
      endcase
    end
  end

  // State, counters and registered outputs, all decoded from the next state.
  always_ff @(posedge rx_std_clkout) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      stable_q  <= '0;
      loss_q    <= '0;
      hold_q    <= '0;
      wa_q      <= 1'b0;
      ena_q     <= 1'b0;
      req_q     <= 1'b0;
      link_up_q <= 1'b0;
      relink_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      stable_q  <= stable_d;
      loss_q    <= loss_d;
      hold_q    <= hold_d;
      wa_q      <= (state_d == StAlign) && (state_q != StAlign);
      ena_q     <= (state_d == StByteord);
      req_q     <= (state_d == StPhyrst) && (state_q != StPhyrst);
      link_up_q <= (state_d == StLinked);
      if ((state_d == StResync) && (state_q != StResync) && (relink_q != 8'hFF)) begin
        relink_q <= relink_q + 1'b1;
      end
    end
  end

  assign rx_std_wa_patternalign = wa_q;
  assign rx_std_byteorder_ena   = ena_q;
  assign phy_reset_req          = req_q;
  assign link_up                = link_up_q;
  assign link_state             = state_q;
  assign relink_cnt             = relink_q;

endmodule

// File: tb/tb_rx_link_align_ctrl.sv
// Directed-plus-random bench for rx_link_align_ctrl. Expected behaviour comes
// from cycle arithmetic on the bring-up/supervision rules, not from the RTL.
module tb_rx_link_align_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rx_ready, rx_is_lockedtodata, flag, sat_rst_n;
  logic [1:0]  sync, errdet, disperr;
  logic        wa, ena, req, link_up;
  logic [2:0]  link_state;
  logic [15:0] err_total;
  logic [7:0]  relink_cnt;
  logic        sat_wa, sat_ena, sat_req, sat_link_up;
  logic [2:0]  sat_state;
  logic [15:0] sat_err_total;
  logic [7:0]  sat_relink;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sat_base = 0;
  int exp_relink = 0;
  int exp_err = 0;

  rx_link_align_ctrl dut (
    .rx_std_clkout          (clk),
    .rst_n                  (rst_n),
    .rx_ready               (rx_ready),
    .rx_is_lockedtodata     (rx_is_lockedtodata),
    .rx_syncstatus          (sync),
    .rx_errdetect           (errdet),
    .rx_disperr             (disperr),
    .rx_std_byteorder_flag  (flag),
    .rx_std_wa_patternalign (wa),
    .rx_std_byteorder_ena   (ena),
    .phy_reset_req          (req),
    .link_up                (link_up),
    .link_state             (link_state),
    .err_total              (err_total),
    .relink_cnt             (relink_cnt)
  );

  // Second instance: threshold unreachable, errors every cycle, to reach saturation.
  rx_link_align_ctrl #(.ERR_THRESH(8192)) sat_dut (
    .rx_std_clkout          (clk),
    .rst_n                  (sat_rst_n),
    .rx_ready               (1'b1),
    .rx_is_lockedtodata     (1'b1),
    .rx_syncstatus          (2'b11),
    .rx_errdetect           (2'b01),
    .rx_disperr             (2'b00),
    .rx_std_byteorder_flag  (1'b1),
    .rx_std_wa_patternalign (sat_wa),
    .rx_std_byteorder_ena   (sat_ena),
    .phy_reset_req          (sat_req),
    .link_up                (sat_link_up),
    .link_state             (sat_state),
    .err_total              (sat_err_total),
    .relink_cnt             (sat_relink)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] bad_sync();
    return 2'($urandom_range(0, 2));
  endfunction

  task automatic chk_cleared(input string tag);
    chk({tag, "_state"},  32'(link_state), 0);
    chk({tag, "_linkup"}, 32'(link_up), 0);
    chk({tag, "_wa"},     32'(wa), 0);
    chk({tag, "_ena"},    32'(ena), 0);
    chk({tag, "_req"},    32'(req), 0);
    chk({tag, "_relink"}, 32'(relink_cnt), 0);
    chk({tag, "_errtot"}, 32'(err_total), 0);
  endtask

  // Called just after the edge that entered ALIGN; clean sync gives 16 cycles there.
  task automatic align_clean(input string tag);
    int pulses = 0;
    sync = 2'b11;
    chk({tag, "_align_entry"}, 32'(link_state), 1);
    chk({tag, "_wa_first"},    32'(wa), 1);
    for (int i = 1; i < 16; i++) begin
      tick();
      pulses += int'(wa);
    end
    chk({tag, "_align_15"}, 32'(link_state), 1);
    tick();
    chk({tag, "_byteord"},   32'(link_state), 2);
    chk({tag, "_ena_on"},    32'(ena), 1);
    chk({tag, "_wa_single"}, 32'(pulses), 0);
  endtask

  // Flag rises in the d-th BYTEORD cycle; link comes up on that edge.
  task automatic byteord_to_linked(input string tag, input int d);
    flag = 1'b0;
    for (int i = 1; i < d; i++) tick();
    chk({tag, "_wait_flag"}, 32'(link_state), 2);
    flag = 1'b1;
    tick();
    flag = 1'b0;
    chk({tag, "_linked"},  32'(link_state), 3);
    chk({tag, "_linkup"},  32'(link_up), 1);
    chk({tag, "_ena_off"}, 32'(ena), 0);
  endtask

  // From ALIGN entry: n0 bad-sync cycles then clean; shared 1024-cycle timeout.
  task automatic timeout_run(input string tag, input int n0);
    int stable_at = n0 + 16;
    int e0 = errors;
    int pulses = 0;
    int exp_st = 1;
    for (int i = 1; i <= 1024; i++) begin
      sync = (i <= n0) ? bad_sync() : 2'b11;
      tick();
      if (i < stable_at && i < 1024)       exp_st = 1;
      else if (i < stable_at)              exp_st = 5;
      else if (i < 1024 || i == stable_at) exp_st = 2;
      else                                 exp_st = 5;
      if (i < 1024) pulses += int'(req);
      chk({tag, "_state"}, 32'(link_state), 32'(exp_st));
      if (errors != e0) break;
    end
    chk({tag, "_req_early"}, 32'(pulses), 0);
    chk({tag, "_req_end"},   32'(req), (exp_st == 5) ? 32'd1 : 32'd0);
  endtask

  initial begin
    bit err_map [12288];
    int wcnt [3];
    int t, k, d, n0, e0;
    logic [3:0] e;
    bit resync_due;

    rst_n = 1'b0; sat_rst_n = 1'b0;
    rx_ready = 1'b0; rx_is_lockedtodata = 1'b0;
    sync = 2'b00; errdet = 2'b00; disperr = 2'b00; flag = 1'b0;
    tick();
    tick();
    chk_cleared("reset");

    // 1: lock and sync present from the first cycle out of reset
    rx_ready = 1'b1; rx_is_lockedtodata = 1'b1; sync = 2'b11;
    rst_n = 1'b1; sat_rst_n = 1'b1;
    sat_base = cyc;
    tick();
    align_clean("t1");
    byteord_to_linked("t1", 6);
    chk("t1_relink", 32'(relink_cnt), 0);

    // 2: short sync loss tolerated, LOSS_CYCLES in a row forces RESYNC
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      sync = bad_sync();
      tick();
      chk("t2_short_loss", 32'(link_state), 3);
    end
    sync = 2'b11;
    tick();
    chk("t2_recovered", 32'(link_state), 3);
    for (int i = 0; i < 3; i++) begin
      sync = bad_sync();
      tick();
      chk("t2_loss_run", 32'(link_state), 3);
    end
    sync = bad_sync();
    tick();
    exp_relink++;
    chk("t2_resync",  32'(link_state), 4);
    chk("t2_linkup0", 32'(link_up), 0);
    chk("t2_relink",  32'(relink_cnt), 32'(exp_relink));
    sync = 2'b11;
    for (int i = 1; i < 32; i++) tick();
    chk("t2_hold_31", 32'(link_state), 4);
    tick();
    chk("t2_realign", 32'(link_state), 1);
    chk("t2_wa",      32'(wa), 1);

    // ALIGN under a random glitchy sync pattern: leave after 16 consecutive good cycles
    begin
      int run = 0;
      int n = 0;
      e0 = errors;
      forever begin
        sync = (n < 300 && $urandom_range(0, 15) == 0) ? bad_sync() : 2'b11;
        run = (sync == 2'b11) ? run + 1 : 0;
        tick();
        n++;
        chk("t2_rand_align", 32'(link_state), (run == 16) ? 32'd2 : 32'd1);
        if (run == 16 || errors != e0) break;
      end
    end
    d = $urandom_range(1, 8);
    byteord_to_linked("t2r", d);

    // 3: window error counting; 7+7 across a wrap is fine, 8 in one window is not
    foreach (err_map[i]) err_map[i] = 1'b0;
    for (int j = 0; j < 6; j++) err_map[j * 682 + $urandom_range(0, 681)] = 1'b1;
    err_map[4095] = 1'b1;
    err_map[4096] = 1'b1;
    for (int j = 0; j < 6; j++) err_map[4097 + j * 682 + $urandom_range(0, 681)] = 1'b1;
    for (int j = 0; j < 8; j++) err_map[8192 + j * 500 + $urandom_range(0, 499)] = 1'b1;
    foreach (wcnt[i]) wcnt[i] = 0;
    resync_due = 1'b0;
    t = 0;
    e0 = errors;
    while (!resync_due && t < 12288) begin
      e = err_map[t] ? 4'($urandom_range(1, 15)) : 4'd0;
      errdet = e[1:0];
      disperr = e[3:2];
      if (err_map[t]) begin
        wcnt[t / 4096]++;
        exp_err++;
        if (wcnt[t / 4096] == 8) resync_due = 1'b1;
      end
      tick();
      chk("t3_state", 32'(link_state), resync_due ? 32'd4 : 32'd3);
      if (t == 8191) chk("t3_errtot_14", 32'(err_total), 32'(exp_err));
      if (errors != e0) break;
      t++;
    end
    errdet = 2'b00; disperr = 2'b00;
    exp_relink++;
    chk("t3_resync_seen", 32'(resync_due), 1);
    chk("t3_errtot",      32'(err_total), 32'(exp_err));
    chk("t3_relink",      32'(relink_cnt), 32'(exp_relink));
    chk("t3_linkup0",     32'(link_up), 0);
    for (int i = 0; i < 32; i++) tick();
    align_clean("t3");
    byteord_to_linked("t3", $urandom_range(1, 8));

    // 5: lock loss on the very cycle the loss run would complete
    for (int i = 0; i < 3; i++) begin
      sync = bad_sync();
      tick();
    end
    chk("t5_pre", 32'(link_state), 3);
    sync = bad_sync();
    rx_is_lockedtodata = 1'b0;
    tick();
    sync = 2'b11;
    chk("t5_idle",    32'(link_state), 0);
    chk("t5_linkup0", 32'(link_up), 0);
    chk("t5_relink",  32'(relink_cnt), 32'(exp_relink));
    k = $urandom_range(1, 5);
    for (int i = 0; i < k; i++) tick();
    chk("t5_stay_idle", 32'(link_state), 0);
    rx_is_lockedtodata = 1'b1;
    tick();
    chk("t5_align", 32'(link_state), 1);

    // 4: no sync at all -> PHY reset request at the timeout
    timeout_run("t4", 1024);
    rx_ready = 1'b0;
    tick();
    chk("t4_idle",     32'(link_state), 0);
    chk("t4_req_drop", 32'(req), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_wait_lock", 32'(link_state), 0);
    rx_ready = 1'b1;
    tick();
    chk("t4_relock", 32'(link_state), 1);

    // Timeout shared across ALIGN and BYTEORD
    n0 = $urandom_range(100, 900);
    timeout_run("t4b", n0);
    tick();
    chk("t4b_idle", 32'(link_state), 0);
    tick();
    chk("t4b_align", 32'(link_state), 1);

    // Stable reached on the timeout cycle, flag on the next: exits win both times
    timeout_run("t4c", 1008);
    flag = 1'b1;
    tick();
    flag = 1'b0;
    chk("t4c_linked", 32'(link_state), 3);
    chk("t4c_linkup", 32'(link_up), 1);
    chk("t4c_errtot", 32'(err_total), 32'(exp_err));
    chk("t4c_relink", 32'(relink_cnt), 32'(exp_relink));

    // 6: synchronous reset in the middle of BYTEORD
    rx_is_lockedtodata = 1'b0;
    tick();
    chk("t6_idle", 32'(link_state), 0);
    rx_is_lockedtodata = 1'b1;
    tick();
    align_clean("t6");
    tick();
    tick();
    chk("t6_in_byteord", 32'(link_state), 2);
    rst_n = 1'b0;
    tick();
    chk_cleared("t6_reset");
    rst_n = 1'b1;
    tick();
    chk("t6_restart", 32'(link_state), 1);

    // err_total saturation: linked after 18 edges, one error per linked cycle
    while (cyc - sat_base < 65552) tick();
    chk("sat_fffe", 32'(sat_err_total), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(sat_err_total), 32'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold",   32'(sat_err_total), 32'hFFFF);
    chk("sat_state",  32'(sat_state), 3);
    chk("sat_relink", 32'(sat_relink), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
